osd_cmd_arbiter: RTL and testbench

//  Serialises OSD command transactions onto the io_osd/io_strobe/io_din bus of the osd block.
//  Two requesters share the bus: port A (host menu) and port B (core info/status popup).

---
 rtl/osd_cmd_arbiter_if.sv | 44 ++++
 rtl/osd_cmd_arbiter.sv | 147 ++++++++++++++
 tb/tb_osd_cmd_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/osd_cmd_arbiter_if.sv
// Bundle of requester handshakes and the osd-side word bus shared by the OSD command arbiter.
// The arbiter takes the slave view; requesters and benches take the master view.
interface osd_cmd_arbiter_if #(
  parameter int LEN_W = 9
);
  logic             a_req;
  logic [7:0]       a_cmd;
  logic [LEN_W-1:0] a_len;
  logic [15:0]      a_data;
  logic             a_data_valid;
  logic             a_data_ready;
  logic             a_grant;
  logic             a_done;

  logic             b_req;
  logic [7:0]       b_cmd;
  logic [LEN_W-1:0] b_len;
  logic [15:0]      b_data;
  logic             b_data_valid;
  logic             b_data_ready;
  logic             b_grant;
  logic             b_done;

  logic             io_osd;
  logic             io_strobe;
  logic [15:0]      io_din;
  logic             busy;

  modport slave (
    input  a_req, a_cmd, a_len, a_data, a_data_valid,
    input  b_req, b_cmd, b_len, b_data, b_data_valid,
    output a_data_ready, a_grant, a_done,
    output b_data_ready, b_grant, b_done,
    output io_osd, io_strobe, io_din, busy
  );

  modport master (
    output a_req, a_cmd, a_len, a_data, a_data_valid,
    output b_req, b_cmd, b_len, b_data, b_data_valid,
    input  a_data_ready, a_grant, a_done,
    input  b_data_ready, b_grant, b_done,
    input  io_osd, io_strobe, io_din, busy
  );
endinterface

// File: rtl/osd_cmd_arbiter.sv
// Round-robin arbiter that serialises command+data transactions from two requesters
// onto the osd io_osd/io_strobe/io_din bus, with GAP-cycle strobe phases.
module osd_cmd_arbiter #(
  parameter int GAP   = 2,
  parameter int LEN_W = 9
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  osd_cmd_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, CMD_HI, CMD_LO, DWAIT, DAT_HI, DAT_LO, GUARD
  } state_e;

  localparam logic [3:0] PH_LAST   = 4'(GAP - 1);
  localparam bit         GUARD_ONE = (GAP == 1);

  state_e           state_q;
  logic [3:0]       phase_q;
  logic [LEN_W-1:0] len_left_q;
  logic             sel_b_q;
  logic             last_b_q;
  logic             a_ready_q, a_grant_q, a_done_q;
  logic             b_ready_q, b_grant_q, b_done_q;
  logic             io_osd_q, io_strobe_q, busy_q;
  logic [15:0]      io_din_q;

  logic             pick_b_d;
  logic             phase_end_d;
  logic             sel_valid_d;
  logic             sel_ready_d;
  logic [15:0]      sel_data_d;

  // On a tie the side that was not served last wins.
  assign pick_b_d    = bus.b_req & (~bus.a_req | ~last_b_q);
  assign phase_end_d = (phase_q == 4'd0);
  assign sel_valid_d = sel_b_q ? bus.b_data_valid : bus.a_data_valid;
  assign sel_ready_d = sel_b_q ? b_ready_q        : a_ready_q;
  assign sel_data_d  = sel_b_q ? bus.b_data       : bus.a_data;

  // NOTE: nonblocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= 4'd0;
      len_left_q  <= '0;
      sel_b_q     <= 1'b0;
      last_b_q    <= 1'b1;
      a_ready_q   <= 1'b0;
      a_grant_q   <= 1'b0;
      a_done_q    <= 1'b0;
      b_ready_q   <= 1'b0;
      b_grant_q   <= 1'b0;
      b_done_q    <= 1'b0;
      io_osd_q    <= 1'b0;
      io_strobe_q <= 1'b0;
      io_din_q    <= 16'h0000;
      busy_q      <= 1'b0;
    end else begin
      a_grant_q <= 1'b0;
      b_grant_q <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;

      // Timed phases count down and reload; IDLE and DWAIT reload on exit.
      if (state_q != IDLE && state_q != DWAIT)
        phase_q <= phase_end_d ? PH_LAST : phase_q - 4'd1;

      case (state_q)
        IDLE: begin
          if (bus.a_req | bus.b_req) begin
            sel_b_q    <= pick_b_d;
            a_grant_q  <= ~pick_b_d;
            b_grant_q  <= pick_b_d;
            io_osd_q   <= 1'b1;
            io_din_q   <= {8'h00, (pick_b_d ? bus.b_cmd : bus.a_cmd)};
            len_left_q <= pick_b_d ? bus.b_len : bus.a_len;
            phase_q    <= PH_LAST;
            busy_q     <= 1'b1;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          if (phase_end_d) begin
            io_strobe_q <= 1'b1;
            state_q     <= CMD_HI;
          end
        end
        CMD_HI, DAT_HI: begin
          if (phase_end_d) begin
            io_strobe_q <= 1'b0;
            state_q     <= (state_q == CMD_HI) ? CMD_LO : DAT_LO;
          end
        end
        CMD_LO, DAT_LO: begin
          if (phase_end_d) begin
            if (len_left_q == '0) begin
              io_osd_q <= 1'b0;
              a_done_q <= GUARD_ONE & ~sel_b_q;
              b_done_q <= GUARD_ONE & sel_b_q;
              state_q  <= GUARD;
            end else begin
              a_ready_q <= ~sel_b_q;
              b_ready_q <= sel_b_q;
              state_q   <= DWAIT;
            end
          end
        end
        DWAIT: begin
          if (sel_valid_d & sel_ready_d) begin
            io_din_q    <= sel_data_d;
            a_ready_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            len_left_q  <= len_left_q - 1'b1;
            io_strobe_q <= 1'b1;
            phase_q     <= PH_LAST;
            state_q     <= DAT_HI;
          end
        end
        GUARD: begin
          if (phase_end_d) begin
            last_b_q <= sel_b_q;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else if (phase_q == 4'd1) begin
            a_done_q <= ~sel_b_q;
            b_done_q <= sel_b_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a_data_ready = a_ready_q;
  assign bus.a_grant      = a_grant_q;
  assign bus.a_done       = a_done_q;
  assign bus.b_data_ready = b_ready_q;
  assign bus.b_grant      = b_grant_q;
  assign bus.b_done       = b_done_q;
  assign bus.io_osd       = io_osd_q;
  assign bus.io_strobe    = io_strobe_q;
  assign bus.io_din       = io_din_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_osd_cmd_arbiter.sv
// Scoreboard bench for osd_cmd_arbiter: expected words, grants and dones are queued as
// stimulus is driven and compared as the bus monitor observes them.
module tb_osd_cmd_arbiter;

  localparam int GAP   = 2;
  localparam int LEN_W = 9;
  localparam int TMO   = 500;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   last_done_cyc = 0;

  logic [15:0] word_q[$];
  logic [1:0]  grant_q[$];
  logic [1:0]  done_q[$];

  osd_cmd_arbiter_if #(.LEN_W(LEN_W)) bus ();

  osd_cmd_arbiter #(.GAP(GAP), .LEN_W(LEN_W)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({bus.a_data_ready, bus.a_grant, bus.a_done,
                bus.b_data_ready, bus.b_grant, bus.b_done,
                bus.io_osd, bus.io_strobe, bus.busy, bus.io_din});
  endfunction

  function automatic logic ready_of(input bit side);
    return side ? bus.b_data_ready : bus.a_data_ready;
  endfunction

  function automatic logic grant_of(input bit side);
    return side ? bus.b_grant : bus.a_grant;
  endfunction

  function automatic logic done_of(input bit side);
    return side ? bus.b_done : bus.a_done;
  endfunction

  task automatic drive_req(input bit side, input logic req, input logic [7:0] cmd,
                           input logic [LEN_W-1:0] len);
    if (side) begin bus.b_req = req; bus.b_cmd = cmd; bus.b_len = len; end
    else      begin bus.a_req = req; bus.a_cmd = cmd; bus.a_len = len; end
  endtask

  task automatic drive_data(input bit side, input logic valid, input logic [15:0] d);
    if (side) begin bus.b_data_valid = valid; bus.b_data = d; end
    else      begin bus.a_data_valid = valid; bus.a_data = d; end
  endtask

  task automatic wait_grant(input bit side, output int n);
    n = 0;
    do begin @(negedge clk_sys); n++; end while (!grant_of(side) && n < TMO);
    check("grant_wait", 32'(grant_of(side)), 1);
  endtask

  task automatic wait_done(input bit side);
    int n = 0;
    do begin @(negedge clk_sys); n++; end while (!done_of(side) && n < TMO);
    check("done_wait", 32'(done_of(side)), 1);
  endtask

  // Bus monitor: word scoreboard, strobe/frame protocol, grant and done ordering.
  logic       prev_strobe = 1'b0;
  logic       prev_done   = 1'b0;
  logic [15:0] prev_din   = 16'h0;
  int         hi_run = 0;
  int         low_run = 0;
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      prev_strobe = 1'b0; prev_done = 1'b0; hi_run = 0; low_run = 0;
    end else begin
      if (bus.io_strobe) begin
        check("strobe_in_frame", 32'(bus.io_osd), 1);
        if (prev_strobe) check("din_stable", 32'(bus.io_din), 32'(prev_din));
        else if (word_q.size() == 0) check("word_unexpected", 32'(word_q.size()), 1);
        else check("word", 32'(bus.io_din), 32'(word_q.pop_front()));
        hi_run++;
      end else if (prev_strobe) begin
        check("strobe_width", 32'(hi_run), 32'(GAP));
        hi_run = 0;
      end
      low_run = bus.io_osd ? 0 : low_run + 1;
      if (bus.a_data_ready | bus.b_data_ready)
        check("ready_excl", 32'(bus.a_data_ready & bus.b_data_ready), 0);
      if (bus.a_grant | bus.b_grant) begin
        check("busy_at_grant", 32'(bus.busy), 1);
        if (grant_q.size() == 0) check("grant_unexpected", 32'(grant_q.size()), 1);
        else check("grant_owner", 32'({bus.a_grant, bus.b_grant}), 32'(grant_q.pop_front()));
      end
      if (prev_done) check("idle_after_done", 32'(bus.busy), 0);
      if (bus.a_done | bus.b_done) begin
        last_done_cyc = cyc;
        check("guard_len", 32'(low_run), 32'(GAP));
        check("done_strobe", 32'(bus.io_strobe), 0);
        if (done_q.size() == 0) check("done_unexpected", 32'(done_q.size()), 1);
        else check("done_owner", 32'({bus.a_done, bus.b_done}), 32'(done_q.pop_front()));
      end
      prev_done   = bus.a_done | bus.b_done;
      prev_strobe = bus.io_strobe;
      prev_din    = bus.io_din;
    end
  end

  task automatic run_txn(input bit side, input logic [7:0] cmd, input int len, input int stall);
    logic [15:0] d[$];
    logic [1:0]  own;
    int          n;
    int          g_cyc;
    own = side ? 2'b01 : 2'b10;
    @(negedge clk_sys);
    word_q.push_back({8'h00, cmd});
    for (int i = 0; i < len; i++) begin
      d.push_back(16'($urandom));
      word_q.push_back(d[i]);
    end
    grant_q.push_back(own);
    done_q.push_back(own);
    drive_req(side, 1'b1, cmd, LEN_W'(len));
    if (len > 0 && stall == 0) drive_data(side, 1'b1, d[0]);
    wait_grant(side, n);
    g_cyc = cyc;
    check("grant_latency", 32'(n), 1);
    // Scramble request inputs right after grant; the latched copy must be used.
    drive_req(side, 1'b0, 8'($urandom), LEN_W'($urandom));
    for (int i = 0; i < len; i++) begin
      if (i == 0 && stall > 0) begin
        n = 0;
        while (!ready_of(side) && n < TMO) begin @(negedge clk_sys); n++; end
        check("dwait_reached", 32'(ready_of(side)), 1);
        for (int s = 0; s < stall; s++) begin
          @(negedge clk_sys);
          check("stall_frame", 32'({bus.io_osd, bus.io_strobe, ready_of(side)}), 32'b101);
        end
      end
      drive_data(side, 1'b1, d[i]);
      n = 0;
      while (!ready_of(side) && n < TMO) begin @(negedge clk_sys); n++; end
      check("ready_wait", 32'(ready_of(side)), 1);
      @(negedge clk_sys);
    end
    drive_data(side, 1'b0, 16'h0000);
    wait_done(side);
    if (stall == 0)
      check("txn_span", 32'(cyc - g_cyc), 32'(4 * GAP + len * (1 + 2 * GAP) - 1));
  endtask

  initial begin
    int n;
    int rises;
    logic p;
    drive_req(1'b0, 1'b0, 8'h00, '0);
    drive_req(1'b1, 1'b0, 8'h00, '0);
    drive_data(1'b0, 1'b0, 16'h0000);
    drive_data(1'b1, 1'b0, 16'h0000);
    #1 check("reset_outputs", all_outputs(), 0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Simultaneous requests from reset: A, then B, then A again.
    word_q.push_back(16'h0011); word_q.push_back(16'h0012); word_q.push_back(16'h0013);
    grant_q.push_back(2'b10); grant_q.push_back(2'b01); grant_q.push_back(2'b10);
    done_q.push_back(2'b10);  done_q.push_back(2'b01);  done_q.push_back(2'b10);
    drive_req(1'b0, 1'b1, 8'h11, '0);
    drive_req(1'b1, 1'b1, 8'h12, '0);
    wait_grant(1'b0, n);
    @(negedge clk_sys);
    bus.a_cmd = 8'h13;
    wait_grant(1'b1, n);
    check("back_to_back_gap", 32'(cyc - last_done_cyc), 2);
    bus.b_req = 1'b0;
    wait_grant(1'b0, n);
    bus.a_req = 1'b0;
    wait_done(1'b0);

    run_txn(1'b0, 8'h41, 0, 0);
    run_txn(1'b0, 8'h20, 3, 0);
    run_txn(1'b1, 8'h25, 2, 10);

    // Asynchronous reset in the first data strobe-high phase.
    @(negedge clk_sys);
    word_q.push_back(16'h0021);
    word_q.push_back(16'hbeef);
    grant_q.push_back(2'b10);
    drive_data(1'b0, 1'b1, 16'hbeef);
    drive_req(1'b0, 1'b1, 8'h21, LEN_W'(2));
    wait_grant(1'b0, n);
    bus.a_req = 1'b0;
    rises = 0; p = 1'b0; n = 0;
    while (rises < 2 && n < TMO) begin
      @(negedge clk_sys); n++;
      if (bus.io_strobe && !p) rises++;
      p = bus.io_strobe;
    end
    check("dat_hi_reached", 32'(rises), 2);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs", all_outputs(), 0);
    drive_data(1'b0, 1'b0, 16'h0000);
    word_q.delete(); grant_q.delete(); done_q.delete();
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      check("post_reset_idle",
            32'({bus.a_done, bus.b_done, bus.a_grant, bus.b_grant, bus.busy}), 0);
    end

    run_txn(1'b1, 8'h43, 1, 0);
    run_txn(1'b0, 8'h22, 2, 0);

    repeat (4) @(negedge clk_sys);
    check("sb_words_left", 32'(word_q.size()), 0);
    check("sb_grants_left", 32'(grant_q.size()), 0);
    check("sb_dones_left", 32'(done_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
